// File: rtl/tx_packet_assembler.sv
// Assembles SYNC/PID/payload/CRC16 byte streams for a serializer, then requests EOP.
// Handshake packets carry only SYNC and PID; DATA0/DATA1 append up to MAX_BYTES and a CRC.
module tx_packet_assembler #(
   parameter int unsigned MAX_BYTES = 64
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] tx_packet,
   input  logic       tx_start,
   input  logic [6:0] buffer_occupancy,
   input  logic [7:0] tx_packet_data,
   input  logic       byte_sent,
   input  logic       eop_done,
   output logic [7:0] tx_byte,
   output logic       byte_valid,
   output logic       get_tx_packet_data,
   output logic       send_eop,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam logic [3:0] StIdle  = 4'd0;
   localparam logic [3:0] StSync  = 4'd1;
   localparam logic [3:0] StPid   = 4'd2;
   localparam logic [3:0] StFetch = 4'd3;
   localparam logic [3:0] StData  = 4'd4;
   localparam logic [3:0] StCrcLo = 4'd5;
   localparam logic [3:0] StCrcHi = 4'd6;
   localparam logic [3:0] StEop   = 4'd7;
   localparam logic [3:0] StDone  = 4'd8;

   // Occupancy is only 7 bits wide, so a larger MAX_BYTES can never be reached.
   localparam int unsigned CapInt = (MAX_BYTES > 127) ? 127 : MAX_BYTES;
   localparam logic [6:0]  LenCap = CapInt[6:0];

   logic [3:0]  state_q, state_d;
   logic [2:0]  ptype_q, ptype_d;
   logic [6:0]  len_q, len_d;
   logic [15:0] crc_q, crc_d;
   logic [7:0]  byte_q, byte_d;
   logic        loaded_q, loaded_d;
   logic        error_q, error_d;
   logic        sent;

   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   function automatic logic [3:0] pid_nibble(input logic [2:0] t);
      case (t)
         3'd1:    return 4'h3;
         3'd2:    return 4'hB;
         3'd3:    return 4'h2;
         3'd4:    return 4'hA;
         3'd5:    return 4'hE;
         default: return 4'h0;
      endcase
   endfunction

   assign sent = byte_valid & byte_sent;

   always_comb begin
      state_d  = state_q;
      ptype_d  = ptype_q;
      len_d    = len_q;
      crc_d    = crc_q;
      byte_d   = byte_q;
      loaded_d = loaded_q;
      error_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (tx_start) begin
               if (tx_packet >= 3'd1 && tx_packet <= 3'd5) begin
                  state_d = StSync;
                  ptype_d = tx_packet;
                  len_d   = (buffer_occupancy > LenCap) ? LenCap : buffer_occupancy;
                  crc_d   = 16'hFFFF;
                  byte_d  = 8'h80;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         StSync: begin
            if (sent) begin
               state_d = StPid;
               byte_d  = {~pid_nibble(ptype_q), pid_nibble(ptype_q)};
            end
         end
         StPid: begin
            if (sent) begin
               if (ptype_q >= 3'd3) begin
                  state_d = StEop;
               end else if (len_q == 7'd0) begin
                  state_d = StCrcLo;
                  byte_d  = ~crc_q[7:0];
               end else begin
                  state_d = StFetch;
               end
            end
         end
         StFetch: begin
            state_d  = StData;
            loaded_d = 1'b0;
         end
         StData: begin
            // Read data arrives during the first DATA cycle; capture it before presenting.
            if (!loaded_q) begin
               byte_d   = tx_packet_data;
               crc_d    = crc_step(crc_q, tx_packet_data);
               len_d    = len_q - 7'd1;
               loaded_d = 1'b1;
            end else if (sent) begin
               if (len_q != 7'd0) begin
                  state_d = StFetch;
               end else begin
                  state_d = StCrcLo;
                  byte_d  = ~crc_q[7:0];
               end
            end
         end
         StCrcLo: begin
            if (sent) begin
               state_d = StCrcHi;
               byte_d  = ~crc_q[15:8];
            end
         end
         StCrcHi: begin
            if (sent) state_d = StEop;
         end
         StEop: begin
            if (eop_done) state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= StIdle;
         ptype_q  <= 3'd0;
         len_q    <= 7'd0;
         crc_q    <= 16'hFFFF;
         byte_q   <= 8'h00;
         loaded_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptype_q  <= ptype_d;
         len_q    <= len_d;
         crc_q    <= crc_d;
         byte_q   <= byte_d;
         loaded_q <= loaded_d;
         error_q  <= error_d;
      end
   end

   assign tx_byte            = byte_q;
   assign tx_error           = error_q;
   assign tx_busy            = (state_q != StIdle);
   assign get_tx_packet_data = (state_q == StFetch);
   assign send_eop           = (state_q == StEop);
   assign tx_done            = (state_q == StDone);
   assign byte_valid         = (state_q == StSync) || (state_q == StPid) ||
                               (state_q == StCrcLo) || (state_q == StCrcHi) ||
                               ((state_q == StData) && loaded_q);

endmodule

// File: tb/tb_tx_packet_assembler.sv
// Scoreboard bench: stimulus pushes expected events from a packet-level model,
// a monitor pops and compares whenever the DUT emits a byte, EOP, done or error.
module tb_tx_packet_assembler;

   localparam int MaxBytes = 64;
   localparam int KByte = 0, KEop = 1, KDone = 2, KErr = 3;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [2:0] tx_packet = '0;
   logic       tx_start = 1'b0;
   logic [6:0] buffer_occupancy = '0;
   logic [7:0] tx_packet_data = '0;
   logic       byte_sent;
   logic       eop_done;
   logic [7:0] tx_byte;
   logic       byte_valid, get_tx_packet_data, send_eop, tx_busy, tx_done, tx_error;

   ev_t        exp_q[$];
   logic [7:0] data_q[$];
   int checks = 0, errors = 0;
   int cyc = 0, eop_cyc = 0, pops = 0;
   int ser_fixed = -1;
   bit spur_en = 1'b0;

   tx_packet_assembler #(.MAX_BYTES(MaxBytes)) dut (
      .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet), .tx_start(tx_start),
      .buffer_occupancy(buffer_occupancy), .tx_packet_data(tx_packet_data),
      .byte_sent(byte_sent), .eop_done(eop_done), .tx_byte(tx_byte),
      .byte_valid(byte_valid), .get_tx_packet_data(get_tx_packet_data),
      .send_eop(send_eop), .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic observe(input int kind, input int val);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d val 0x%0h, expected nothing (t=%0t)",
                  kind, val, $time);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_value", val, e.val);
      end
   endtask

   function automatic void push(input int kind, input int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endfunction

   function automatic logic [7:0] pid_byte(input int t);
      case (t)
         1:       return 8'hC3;
         2:       return 8'h4B;
         3:       return 8'hD2;
         4:       return 8'h5A;
         default: return 8'h1E;
      endcase
   endfunction

   // Fills the buffer and queues everything the packet should produce.
   task automatic load_packet(input int t, input int occ, input bit seq);
      int n;
      logic [15:0] crc;
      data_q.delete();
      for (int i = 0; i < occ; i++) data_q.push_back(seq ? 8'(8'h31 + i) : 8'($urandom));
      if (t < 1 || t > 5) begin
         push(KErr, 0);
         return;
      end
      push(KByte, 8'h80);
      push(KByte, pid_byte(t));
      n = 0;
      if (t <= 2) begin
         n = (occ < MaxBytes) ? occ : MaxBytes;
         crc = 16'hFFFF;
         for (int i = 0; i < n; i++) begin
            push(KByte, data_q[i]);
            crc = crc ^ {8'h00, data_q[i]};
            for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
         end
         crc = ~crc;
         push(KByte, crc[7:0]);
         push(KByte, crc[15:8]);
      end
      push(KEop, 0);
      push(KDone, n);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d events pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic pulse_start(input int t, input int occ);
      @(posedge clk); #1;
      tx_packet = 3'(t);
      buffer_occupancy = 7'(occ);
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
      tx_packet = 3'($urandom);
      buffer_occupancy = 7'($urandom);
   endtask

   task automatic send(input int t, input int occ, input bit seq, input bit poke);
      load_packet(t, occ, seq);
      pulse_start(t, occ);
      if (poke) begin
         repeat (2) @(posedge clk);
         pulse_start(4, 5);
         repeat (2) @(posedge clk);
         pulse_start(7, 9);
      end
      wait_drain();
   endtask

   // Serializer: accepts presented bytes after a delay, sometimes pulses while idle.
   initial begin
      int d;
      byte_sent = 1'b0;
      forever begin
         @(posedge clk); #1;
         byte_sent = 1'b0;
         if (byte_valid) begin
            d = (ser_fixed >= 0) ? ser_fixed : int'($urandom_range(0, 3));
            repeat (d) begin
               @(posedge clk); #1;
            end
            if (byte_valid) byte_sent = 1'b1;
         end else if (spur_en && $urandom_range(0, 3) == 0) begin
            byte_sent = 1'b1;
         end
      end
   end

   // Line encoder.
   initial begin
      eop_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         eop_done = 1'b0;
         if (send_eop) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk); #1;
            end
            if (send_eop && n_rst) begin
               eop_done = 1'b1;
               eop_cyc = cyc;
            end
         end
      end
   end

   // TX buffer: data appears the cycle after a pop request.
   initial begin
      forever begin
         @(negedge clk);
         if (get_tx_packet_data && n_rst) begin
            @(posedge clk); #1;
            tx_packet_data = (data_q.size() != 0) ? data_q.pop_front() : 8'hEE;
         end
      end
   end

   // Monitor.
   initial begin
      logic       prev_valid, prev_acc, prev_eop;
      logic [7:0] prev_byte;
      prev_valid = 1'b0; prev_acc = 1'b0; prev_eop = 1'b0; prev_byte = 8'h00;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            prev_valid = 1'b0; prev_acc = 1'b0; prev_eop = 1'b0; prev_byte = tx_byte;
            pops = 0;
            continue;
         end
         if (byte_valid && prev_valid && !prev_acc) chk("tx_byte_stable", tx_byte, prev_byte);
         if (!byte_valid && !prev_valid) chk("tx_byte_hold", tx_byte, prev_byte);
         if (byte_valid && byte_sent) observe(KByte, tx_byte);
         if (send_eop && !prev_eop) begin
            observe(KEop, 0);
            chk("eop_byte_valid_low", byte_valid, 0);
         end
         if (get_tx_packet_data) pops++;
         if (tx_done) begin
            observe(KDone, pops);
            chk("done_after_eop_done", cyc, eop_cyc + 1);
            pops = 0;
         end
         if (tx_error) observe(KErr, 0);
         prev_valid = byte_valid;
         prev_acc   = byte_valid && byte_sent;
         prev_eop   = send_eop;
         prev_byte  = tx_byte;
      end
   end

   initial begin
      #3000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      n_rst = 1'b1;
      #2 n_rst = 1'b0;
      #1;
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_byte_valid", byte_valid, 0);
      chk("rst_get", get_tx_packet_data, 0);
      chk("rst_send_eop", send_eop, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_error", tx_error, 0);
      repeat (3) @(posedge clk);
      #3 n_rst = 1'b1;
      repeat (3) @(posedge clk);

      send(3, 12, 1'b0, 1'b0);            // ACK, no pops
      send(1, 0, 1'b0, 1'b0);             // DATA0, zero length
      send(2, 9, 1'b1, 1'b0);             // DATA1 "123456789"
      ser_fixed = 5;
      send(1, 70, 1'b0, 1'b0);            // capped at MAX_BYTES, slow serializer
      ser_fixed = -1;
      send(6, 4, 1'b0, 1'b0);             // invalid types
      send(0, 4, 1'b0, 1'b0);
      send(7, 4, 1'b0, 1'b0);
      send(2, 5, 1'b0, 1'b1);             // starts while busy are ignored
      send(5, 0, 1'b0, 1'b0);
      send(4, 0, 1'b0, 1'b0);

      // Reset mid-DATA, then a fresh ACK.
      load_packet(1, 10, 1'b0);
      pulse_start(1, 10);
      n = 0;
      while (!(pops >= 3 && byte_valid) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("reached_data_before_reset", int'(pops >= 3 && byte_valid), 1);
      #2 n_rst = 1'b0;
      #1;
      chk("midrst_tx_byte", tx_byte, 0);
      chk("midrst_byte_valid", byte_valid, 0);
      chk("midrst_get", get_tx_packet_data, 0);
      chk("midrst_send_eop", send_eop, 0);
      chk("midrst_busy", tx_busy, 0);
      chk("midrst_done", tx_done, 0);
      chk("midrst_error", tx_error, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 n_rst = 1'b1;
      repeat (2) @(posedge clk);
      send(3, 0, 1'b0, 1'b0);

      spur_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         int t, occ;
         t   = $urandom_range(0, 7);
         occ = $urandom_range(0, 80);
         send(t, occ, 1'b0, (t == 1 || t == 2) && occ >= 3 && ($urandom_range(0, 1) == 1));
      end
      spur_en = 1'b0;
      repeat (5) @(posedge clk);
      chk("final_idle", tx_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
